rr_sel_arbiter: RTL and testbench
=================================

Name: rr_sel_arbiter

Overview:
- 4-channel round-robin arbiter that generates the 2-bit select and a one-hot grant for the downstream 4:1 data mux (D[3:0], S[1:0] -> Y).
- Requesters raise req; the arbiter grants one channel at a time and drives sel into the mux's S input.
- It holds the grant until the owner releases it, then rotates fairly.
- Registered outputs only, so mux select changes are glitch-free and aligned to clk.

Parameters:
- N_CH, 4, number of request channels (fixed to match the 4:1 mux; other values unsupported).
- SEL_W, 2, select width, equal to log2(N_CH).
- MAX_HOLD, 8, maximum grant hold in cycles; used only when ARB_TIMEOUT_EN is defined; legal range 2..255.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N_CH  per-channel request; level-sensitive.
- gnt  output  N_CH  one-hot grant, registered.
- sel  output  SEL_W  binary index of the granted channel; drives the mux S.
- sel_valid  output  1  high while a grant is active, i.e. sel is meaningful.
- preempt  output  1  one-cycle pulse when a grant is forcibly revoked; constant 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (rst=1 at an edge): gnt=0, sel=0, sel_valid=0, preempt=0, state=IDLE, last pointer=3 so channel 0 has top priority first. Reset mid-grant takes effect at the next edge with the same values; no partial release.
- States: IDLE, GRANT.
- IDLE:
  - If any req bit is high, the next edge moves to GRANT.
  - The winner is the first set req bit searching last+1, last+2, ... mod 4.
  - That edge sets gnt=one-hot(winner), sel=winner, sel_valid=1. Latency from req rise to gnt is 1 cycle.
  - If req=0, remain in IDLE.
- GRANT, hold (req[sel]=1): outputs are unchanged.
- GRANT, release (req[sel]=0):
  - last <= sel, then re-arbitrate over the current req using the same search order. The released channel is searched last and is 0 that cycle.
  - If a winner exists, the grant moves to it at that edge. There is no idle bubble; gnt changes directly from one one-hot value to another.
  - If no winner exists, go to IDLE: gnt=0, sel_valid=0, sel keeps its last value.
- gnt is always zero or one-hot; sel equals the index of the gnt bit whenever sel_valid=1.
- Simultaneous rise of several req bits: only the rotation winner is granted; the others wait.
- Wrap-around: after channel 3 is released, search order is 0,1,2,3.
- A requester that drops and re-raises in a later cycle is treated as a new request with normal rotation priority.
- Fairness: with all 4 requesting continuously and each releasing after its grant, the grant order is 0,1,2,3,0,...

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A hold counter clears on every new grant and increments each GRANT cycle.
  - When the counter reaches MAX_HOLD-1 and any other req bit is high, the next edge forces re-arbitration as if the owner had released. That edge pulses preempt=1 for one cycle.
  - The preempted channel gets lowest priority (last <= sel).
  - With no other requester, the owner keeps the grant and the counter saturates.
- Not defined: no counter logic; preempt tied to 0; grants are held indefinitely.

Decomposition:
- Package rr_sel_arbiter_pkg:
  - N_CH and SEL_W constants.
  - State enum {IDLE, GRANT}.
  - LAST_RST=3 constant.
  - A function converting a one-hot value to an index.
- Sub-module rr_pick:
  - Purely combinational; inputs req[3:0] and last[1:0]; outputs found and idx[1:0].
  - Implements the rotated priority search.
  - Verified standalone with all 64 combinations.

Test Plan:
- Assert rst for 2 cycles with req=4'b1111 -> gnt=0, sel=0, sel_valid=0 throughout; after rst falls, next edge gives gnt=0001, sel=0.
- req=0100 from IDLE -> 1 cycle later gnt=0100, sel=2, sel_valid=1. Drop req to 0000 -> next edge gnt=0000, sel_valid=0, sel stays 2.
- req=1111, owner releases for one cycle after each 2-cycle grant -> sel sequence 0,1,2,3,0 with no cycle where sel_valid=0.
- Owner sel=1 releases while req=1001 -> next edge gnt=1000, sel=3 (search 2,3,0,1).
- Assert rst mid-grant with sel=3 held -> next edge all outputs 0; first grant afterwards with req=1010 is channel 1.
- ARB_TIMEOUT_EN, MAX_HOLD=8: ch0 holds, ch2 requesting -> grant moves to ch2 exactly 8 cycles after ch0's grant, preempt=1 for 1 cycle. Without the macro -> ch0 holds indefinitely, preempt=0.

Source files
------------

// File: rtl/rr_sel_arbiter_pkg.sv
// rr_sel_arbiter_pkg
// Shared constants, the FSM state type and a one-hot to index helper for the
// 4-channel round-robin select arbiter.
//   N_CH     : number of request channels (fixed at 4 to match the 4:1 mux)
//   SEL_W    : select width, log2(N_CH)
//   LAST_RST : reset value of the rotation pointer (3 -> channel 0 wins first)
package rr_sel_arbiter_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic [SEL_W-1:0] LAST_RST = 2'd3;

  // OR-reduction form: no priority chain, exact for a one-hot input and
  // returns 0 for an all-zero input.
  function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [N_CH-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (oh[i]) idx = idx | SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_sel_arbiter_if.sv
// rr_sel_arbiter_if
// Request/grant bundle between the requesters and the arbiter.
//   req       : per-channel request, level-sensitive (requester -> arbiter)
//   gnt       : one-hot grant, registered (arbiter -> requesters)
//   sel       : binary index of the granted channel, drives the mux S input
//   sel_valid : high while a grant is active
//   preempt   : one-cycle pulse when a grant is forcibly revoked
// Handshake: req[i] is the channel's "valid" and stays high for as long as the
// channel wants the mux; gnt[i] is the "ready/accept" and is held while req[i]
// stays high. Dropping req[i] while granted is the release; the grant moves on
// at the next rising edge.
// Modports: master = requester side, slave = arbiter side.
interface rr_sel_arbiter_if;
  import rr_sel_arbiter_pkg::*;

  logic [N_CH-1:0]  req;
  logic [N_CH-1:0]  gnt;
  logic [SEL_W-1:0] sel;
  logic             sel_valid;
  logic             preempt;

  modport master (
    output req,
    input  gnt,
    input  sel,
    input  sel_valid,
    input  preempt
  );

  modport slave (
    input  req,
    output gnt,
    output sel,
    output sel_valid,
    output preempt
  );

endinterface

// File: rtl/rr_sel_arbiter_pick.sv
// rr_pick
// Combinational rotated priority search. Candidates are examined in the order
// last+1, last+2, last+3, last (mod 4); the first one with its req bit set wins.
//   req_i   : request vector
//   last_i  : index of the most recently served channel (searched last)
//   found_o : at least one request is set
//   idx_o   : winning channel index (0 when found_o is low)
module rr_pick
  import rr_sel_arbiter_pkg::*;
(
  input  logic [N_CH-1:0]  req_i,
  input  logic [SEL_W-1:0] last_i,
  output logic             found_o,
  output logic [SEL_W-1:0] idx_o
);

  logic [SEL_W-1:0] cand;
  logic             hit;

  always_comb begin
    cand    = '0;
    hit     = 1'b0;
    idx_o   = '0;
    for (int i = 1; i <= N_CH; i++) begin
      // SEL_W-bit addition wraps modulo N_CH; i == N_CH lands back on last_i.
      cand = last_i + SEL_W'(i);
      if (!hit && req_i[cand]) begin
        hit   = 1'b1;
        idx_o = cand;
      end
    end
    found_o = hit;
  end

endmodule

// File: rtl/rr_sel_arbiter.sv
// rr_sel_arbiter
// 4-channel round-robin arbiter producing the one-hot grant and 2-bit select
// for a downstream 4:1 mux. All outputs are registered.
//   clk     : system clock, rising-edge
//   rst     : synchronous, active-high reset
//   bus     : rr_sel_arbiter_if.slave (req in; gnt, sel, sel_valid, preempt out)
//   state_o : current FSM state (IDLE/GRANT), for observation
// Optional feature macro: ARB_TIMEOUT_EN. When defined, a grant held for
// MAX_HOLD cycles while another channel requests is revoked (preempt pulses).
// When undefined, grants are held until released and preempt is tied low.
module rr_sel_arbiter
  import rr_sel_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst,
  rr_sel_arbiter_if.slave   bus,
  output state_e            state_o
);

  state_e           state_q;
  logic [N_CH-1:0]  gnt_q;
  logic [SEL_W-1:0] sel_q;
  logic             sel_valid_q;
  logic             preempt_q;
  logic [SEL_W-1:0] last_q;

  logic [SEL_W-1:0] owner_idx;
  logic             owner_release;
  logic             force_rearb;
  logic             rearb;
  logic [SEL_W-1:0] pick_last;
  logic             found;
  logic [SEL_W-1:0] win_idx;
  logic [N_CH-1:0]  win_oh;

  assign owner_idx     = onehot_to_idx(gnt_q);
  assign owner_release = (state_q == GRANT) && !bus.req[owner_idx];

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_cnt_q;
  logic       others_req;

  assign others_req  = |(bus.req & ~gnt_q);
  assign force_rearb = (state_q == GRANT) && (hold_cnt_q == 8'(MAX_HOLD - 1)) &&
                       others_req;

  // Clears on every new grant, counts GRANT cycles, saturates at MAX_HOLD-1
  // so a lone owner keeps the grant without wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_q <= '0;
    end else if (found && ((state_q == IDLE) || rearb)) begin
      hold_cnt_q <= '0;
    end else if ((state_q == GRANT) && (hold_cnt_q != 8'(MAX_HOLD - 1))) begin
      hold_cnt_q <= hold_cnt_q + 8'd1;
    end
  end
`else
  localparam int UNUSED_MAX_HOLD = MAX_HOLD;
  assign force_rearb = 1'b0;
`endif

  assign rearb = owner_release || force_rearb;

  // On release/preempt the outgoing owner becomes the new "last" in the same
  // cycle, so it is searched last and the grant can hand over without a bubble.
  assign pick_last = rearb ? owner_idx : last_q;
  assign win_oh    = N_CH'(1) << win_idx;

  rr_pick u_pick (
    .req_i   (bus.req),
    .last_i  (pick_last),
    .found_o (found),
    .idx_o   (win_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      sel_q       <= '0;
      sel_valid_q <= 1'b0;
      preempt_q   <= 1'b0;
      last_q      <= LAST_RST;
    end else begin
      case (state_q)
        IDLE: begin
          preempt_q <= 1'b0;
          if (found) begin
            state_q     <= GRANT;
            gnt_q       <= win_oh;
            sel_q       <= win_idx;
            sel_valid_q <= 1'b1;
          end
        end
        GRANT: begin
          if (rearb) begin
            last_q    <= owner_idx;
            // A voluntary release is never reported as a preemption.
            preempt_q <= !owner_release;
            if (found) begin
              gnt_q <= win_oh;
              sel_q <= win_idx;
            end else begin
              state_q     <= IDLE;
              gnt_q       <= '0;
              sel_valid_q <= 1'b0;
            end
          end else begin
            preempt_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          gnt_q       <= '0;
          sel_valid_q <= 1'b0;
          preempt_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.sel_valid = sel_valid_q;
  assign bus.preempt   = preempt_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_rr_sel_arbiter.sv
module tb_rr_sel_arbiter;
  import rr_sel_arbiter_pkg::*;

  logic   clk;
  logic   rst;
  state_e state;
  int     n_cmp;
  int     n_fail;

  rr_sel_arbiter_if bus ();

  rr_sel_arbiter #(.MAX_HOLD(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .state_o (state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    bus.req = 4'b0000;
    tick();
    rst     = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst     = 1'b1;
    bus.req = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++;
      if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", bus.gnt); end
      n_cmp++;
      if (bus.sel !== 2'd0) begin n_fail++; $display("FAIL reset_sel: got %0d want 0", bus.sel); end
      n_cmp++;
      if (bus.sel_valid !== 1'b0) begin n_fail++; $display("FAIL reset_sel_valid: got %b want 0", bus.sel_valid); end
      n_cmp++;
      if (bus.preempt !== 1'b0) begin n_fail++; $display("FAIL reset_preempt: got %b want 0", bus.preempt); end
      n_cmp++;
      if (state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", state); end
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL post_reset_gnt: got %b want 0001", bus.gnt); end
    n_cmp++;
    if (bus.sel !== 2'd0) begin n_fail++; $display("FAIL post_reset_sel: got %0d want 0", bus.sel); end
    n_cmp++;
    if (state !== GRANT) begin n_fail++; $display("FAIL post_reset_state: got %0d want GRANT", state); end
    bus.req = 4'b0000;
    tick();
    n_cmp++;
    if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL post_reset_release_gnt: got %b want 0000", bus.gnt); end
  endtask

  task automatic test_single();
    bus.req = 4'b0100;
    tick();
    n_cmp++;
    if (bus.gnt !== 4'b0100) begin n_fail++; $display("FAIL single_gnt: got %b want 0100", bus.gnt); end
    n_cmp++;
    if (bus.sel !== 2'd2) begin n_fail++; $display("FAIL single_sel: got %0d want 2", bus.sel); end
    n_cmp++;
    if (bus.sel_valid !== 1'b1) begin n_fail++; $display("FAIL single_sel_valid: got %b want 1", bus.sel_valid); end
    bus.req = 4'b0000;
    tick();
    n_cmp++;
    if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL single_rel_gnt: got %b want 0000", bus.gnt); end
    n_cmp++;
    if (bus.sel_valid !== 1'b0) begin n_fail++; $display("FAIL single_rel_sel_valid: got %b want 0", bus.sel_valid); end
    n_cmp++;
    if (bus.sel !== 2'd2) begin n_fail++; $display("FAIL single_rel_sel_hold: got %0d want 2", bus.sel); end
    n_cmp++;
    if (state !== IDLE) begin n_fail++; $display("FAIL single_rel_state: got %0d want IDLE", state); end
  endtask

  task automatic test_fairness();
    logic [1:0] exp_sel_seq [5];
    logic [3:0] exp_gnt_seq [5];
    exp_sel_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_gnt_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    bus.req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      // first cycle of the grant, then one hold cycle, then a one-cycle release
      for (int h = 0; h < 2; h++) begin
        n_cmp++;
        if (bus.gnt !== exp_gnt_seq[k]) begin n_fail++; $display("FAIL fair_gnt[%0d.%0d]: got %b want %b", k, h, bus.gnt, exp_gnt_seq[k]); end
        n_cmp++;
        if (bus.sel !== exp_sel_seq[k]) begin n_fail++; $display("FAIL fair_sel[%0d.%0d]: got %0d want %0d", k, h, bus.sel, exp_sel_seq[k]); end
        n_cmp++;
        if (bus.sel_valid !== 1'b1) begin n_fail++; $display("FAIL fair_sel_valid[%0d.%0d]: got %b want 1", k, h, bus.sel_valid); end
        bus.req = (h == 0) ? 4'b1111 : ~exp_gnt_seq[k];
        tick();
      end
      bus.req = 4'b1111;
    end
    bus.req = 4'b0000;
    tick();
  endtask

  task automatic test_skip();
    do_reset();
    bus.req = 4'b0010;
    tick();
    n_cmp++;
    if (bus.sel !== 2'd1) begin n_fail++; $display("FAIL skip_setup_sel: got %0d want 1", bus.sel); end
    bus.req = 4'b1001;
    tick();
    n_cmp++;
    if (bus.gnt !== 4'b1000) begin n_fail++; $display("FAIL skip_gnt: got %b want 1000", bus.gnt); end
    n_cmp++;
    if (bus.sel !== 2'd3) begin n_fail++; $display("FAIL skip_sel: got %0d want 3", bus.sel); end
  endtask

  // Continues from test_skip: channel 3 owns the grant.
  task automatic test_reset_mid_grant();
    bus.req = 4'b1000;
    tick();
    n_cmp++;
    if (bus.gnt !== 4'b1000) begin n_fail++; $display("FAIL mid_hold_gnt: got %b want 1000", bus.gnt); end
    rst = 1'b1;
    tick();
    n_cmp++;
    if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_gnt: got %b want 0000", bus.gnt); end
    n_cmp++;
    if (bus.sel !== 2'd0) begin n_fail++; $display("FAIL mid_rst_sel: got %0d want 0", bus.sel); end
    n_cmp++;
    if (bus.sel_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_sel_valid: got %b want 0", bus.sel_valid); end
    n_cmp++;
    if (state !== IDLE) begin n_fail++; $display("FAIL mid_rst_state: got %0d want IDLE", state); end
    rst     = 1'b0;
    bus.req = 4'b1010;
    tick();
    n_cmp++;
    if (bus.gnt !== 4'b0010) begin n_fail++; $display("FAIL mid_after_gnt: got %b want 0010", bus.gnt); end
    n_cmp++;
    if (bus.sel !== 2'd1) begin n_fail++; $display("FAIL mid_after_sel: got %0d want 1", bus.sel); end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.req = 4'b1000;
    tick();
    n_cmp++;
    if (bus.sel !== 2'd3) begin n_fail++; $display("FAIL wrap_setup_sel: got %0d want 3", bus.sel); end
    bus.req = 4'b0111;
    tick();
    n_cmp++;
    if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL wrap_gnt: got %b want 0001", bus.gnt); end
    // channel 0 releases; 1 drops and re-raises later, 2 is next in rotation
    bus.req = 4'b0100;
    tick();
    n_cmp++;
    if (bus.gnt !== 4'b0100) begin n_fail++; $display("FAIL wrap_next_gnt: got %b want 0100", bus.gnt); end
    bus.req = 4'b0011;
    tick();
    n_cmp++;
    if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL wrap_rerequest_gnt: got %b want 0001", bus.gnt); end
    bus.req = 4'b0000;
    tick();
  endtask

  task automatic test_hold_timeout();
    do_reset();
    bus.req = 4'b0001;
    tick();
    n_cmp++;
    if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL hold_start_gnt: got %b want 0001", bus.gnt); end
    bus.req = 4'b0101;
    for (int c = 1; c <= 7; c++) begin
      tick();
      n_cmp++;
      if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL hold_gnt[%0d]: got %b want 0001", c, bus.gnt); end
      n_cmp++;
      if (bus.preempt !== 1'b0) begin n_fail++; $display("FAIL hold_preempt[%0d]: got %b want 0", c, bus.preempt); end
    end
    tick();
`ifdef ARB_TIMEOUT_EN
    n_cmp++;
    if (bus.gnt !== 4'b0100) begin n_fail++; $display("FAIL timeout_gnt: got %b want 0100", bus.gnt); end
    n_cmp++;
    if (bus.sel !== 2'd2) begin n_fail++; $display("FAIL timeout_sel: got %0d want 2", bus.sel); end
    n_cmp++;
    if (bus.preempt !== 1'b1) begin n_fail++; $display("FAIL timeout_preempt: got %b want 1", bus.preempt); end
    bus.req = 4'b0100;
    for (int c = 0; c < 12; c++) begin
      tick();
      n_cmp++;
      if (bus.gnt !== 4'b0100) begin n_fail++; $display("FAIL sat_gnt[%0d]: got %b want 0100", c, bus.gnt); end
      n_cmp++;
      if (bus.preempt !== 1'b0) begin n_fail++; $display("FAIL sat_preempt[%0d]: got %b want 0", c, bus.preempt); end
    end
`else
    for (int c = 8; c < 20; c++) begin
      n_cmp++;
      if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL nohold_gnt[%0d]: got %b want 0001", c, bus.gnt); end
      n_cmp++;
      if (bus.preempt !== 1'b0) begin n_fail++; $display("FAIL nohold_preempt[%0d]: got %b want 0", c, bus.preempt); end
      tick();
    end
`endif
    bus.req = 4'b0000;
    tick();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    rst     = 1'b1;
    bus.req = 4'b0000;
    test_reset();
    test_single();
    test_fairness();
    test_skip();
    test_reset_mid_grant();
    test_wrap();
    test_hold_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
